sm4_axis_block_packer: RTL and testbench

SM4_AXIS_BLOCK_PACKER -- requirements
Module: sm4_axis_block_packer

---
 rtl/sm4_axis_block_packer.sv | 178 +++++++++++++++++
 tb/tb_sm4_axis_block_packer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_axis_block_packer.sv
// Packs an AXI-Stream byte stream into 128-bit blocks for an SM4 core,
// with zero or PKCS#7 padding on the final block of each packet.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_FILL   | accepting beats into the accumulator (s_axis_tready high)
// ST_HOLD   | accumulator complete, waiting for the output register
// ST_PADBLK | packet ended on a full block, extra 0x10 pad block pending
module sm4_axis_block_packer #(
    parameter int S_BYTES  = 1,
    parameter int USER_W   = 8,
    parameter int PAD_MODE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*S_BYTES-1:0]   s_axis_tdata,
    input  logic [S_BYTES-1:0]     s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [USER_W-1:0]      s_axis_tuser,
    output logic [127:0]           m_blk_data,
    output logic                   m_blk_valid,
    input  logic                   m_blk_ready,
    output logic                   m_blk_last,
    output logic [4:0]             m_blk_pad,
    output logic [USER_W-1:0]      m_blk_user
);

    typedef enum logic [1:0] {ST_FILL, ST_HOLD, ST_PADBLK} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_live;
    logic [127:0]        r_acc;
    logic [4:0]          r_fill;
    logic                r_pkt_end;
    logic                r_first;
    logic [USER_W-1:0]   r_user;

    logic                r_out_valid;
    logic [127:0]        r_out_data;
    logic                r_out_last;
    logic [4:0]          r_out_pad;
    logic [USER_W-1:0]   r_out_user;

    logic                w_beat;
    logic                w_slot_free;
    logic                w_move;
    logic                w_padblk_go;
    logic                w_need_padblk;
    logic [4:0]          w_beat_bytes;
    logic [4:0]          w_fill_app;
    logic [127:0]        w_beat_word;
    logic [127:0]        w_acc_app;
    logic [4:0]          w_pad_n;
    logic [7:0]          w_pad_byte;
    logic [127:0]        w_padded;
    logic                w_blk_last;

    // r_live keeps tready low until the first edge after reset release
    assign s_axis_tready = r_live && (r_state == ST_FILL);
    assign w_beat        = s_axis_tvalid && s_axis_tready;
    assign w_slot_free   = !r_out_valid || m_blk_ready;
    assign w_move        = (r_state == ST_HOLD) && w_slot_free;
    assign w_padblk_go   = (r_state == ST_PADBLK) && w_slot_free;
    assign w_fill_app    = r_fill + w_beat_bytes;

    // A packet ending exactly on a full block needs a separate all-pad block in PKCS#7 mode
    assign w_need_padblk = (PAD_MODE == 1) && r_pkt_end && (r_fill == 5'd16);
    assign w_blk_last    = r_pkt_end && !w_need_padblk;

    assign w_pad_n       = 5'd16 - r_fill;
    assign w_pad_byte    = (PAD_MODE == 1) ? {3'b000, w_pad_n} : 8'h00;

    assign m_blk_valid   = r_out_valid;
    assign m_blk_data    = r_out_data;
    assign m_blk_last    = r_out_last;
    assign m_blk_pad     = r_out_pad;
    assign m_blk_user    = r_out_user;

    // Byte count of the current beat: full width, or up to the highest kept lane on tlast
    always_comb begin
        w_beat_bytes = 5'(S_BYTES);
        if (s_axis_tlast && (s_axis_tkeep != '0)) begin
            w_beat_bytes = '0;
            for (int i = 0; i < S_BYTES; i++) begin
                if (s_axis_tkeep[i]) w_beat_bytes = 5'(i + 1);
            end
        end
    end

    // Left-align the valid beat bytes, then shift them behind the bytes already held
    always_comb begin
        w_beat_word = '0;
        for (int j = 0; j < S_BYTES; j++) begin
            if (5'(j) < w_beat_bytes) w_beat_word[127-8*j -: 8] = s_axis_tdata[8*j +: 8];
        end
        w_acc_app = r_acc | (w_beat_word >> {r_fill, 3'b000});
    end

    // Fill the unused tail of the accumulator with pad bytes
    always_comb begin
        w_padded = '0;
        for (int p = 0; p < 16; p++) begin
            w_padded[127-8*p -: 8] = (5'(p) < r_fill) ? r_acc[127-8*p -: 8] : w_pad_byte;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FILL;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL:   if (w_beat && ((w_fill_app == 5'd16) || s_axis_tlast)) w_state_nxt = ST_HOLD;
            ST_HOLD:   if (w_slot_free) w_state_nxt = w_need_padblk ? ST_PADBLK : ST_FILL;
            ST_PADBLK: if (w_slot_free) w_state_nxt = ST_FILL;
            default:   w_state_nxt = ST_FILL;
        endcase
    end

    // Accumulator, fill count and packet tag tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_acc     <= '0;
            r_fill    <= '0;
            r_pkt_end <= 1'b0;
            r_first   <= 1'b1;
            r_user    <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_beat) begin
                r_acc     <= w_acc_app;
                r_fill    <= w_fill_app;
                r_pkt_end <= s_axis_tlast;
                r_first   <= s_axis_tlast;
                if (r_first) r_user <= s_axis_tuser;
            end else if (w_move) begin
                r_acc     <= '0;
                r_fill    <= '0;
                r_pkt_end <= 1'b0;
            end
        end
    end

    // Output register: loaded from HOLD or PADBLK, cleared only by an accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_pad   <= '0;
            r_out_user  <= '0;
        end else if (w_move) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_padded;
            r_out_last  <= w_blk_last;
            r_out_pad   <= w_pad_n;
            r_out_user  <= r_user;
        end else if (w_padblk_go) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {16{8'h10}};
            r_out_last  <= 1'b1;
            r_out_pad   <= 5'd16;
            r_out_user  <= r_user;
        end else if (m_blk_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sm4_axis_block_packer.sv
// Bench for sm4_axis_block_packer: four configurations share one stimulus
// bus, a select picks the active one, and a scoreboard checks every block.
`timescale 1ns/1ps
module tb_sm4_axis_block_packer;

    typedef struct packed {
        logic [127:0] d;
        logic         l;
        logic [4:0]   p;
        logic [7:0]   u;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] tdata = '0;
    logic [15:0]  tkeep = '0;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;
    logic [7:0]   tuser = '0;
    logic         m_ready = 1'b1;
    logic         rand_ready = 1'b0;
    logic [1:0]   sel = 2'd0;
    int           cur_s = 1;
    int           cur_pm = 1;

    logic         tv [4];
    logic         mr [4];
    logic         trdy [4];
    logic [127:0] md [4];
    logic         mv [4];
    logic         ml [4];
    logic [4:0]   mp [4];
    logic [7:0]   mu [4];

    logic         o_tready, o_valid, o_last;
    logic [127:0] o_data;
    logic [4:0]   o_pad;
    logic [7:0]   o_user;

    int           n_vec = 0;
    int           n_fail = 0;
    int           cyc = 0;
    blk_t         exp_q[$];
    int           xfer_cyc[$];
    logic [7:0]   pkt[$];
    blk_t         mon_got, mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tv[i] = tvalid && (sel == 2'(i));
            mr[i] = (sel == 2'(i)) ? m_ready : 1'b1;
        end
    end

    assign o_tready = trdy[sel];
    assign o_valid  = mv[sel];
    assign o_data   = md[sel];
    assign o_last   = ml[sel];
    assign o_pad    = mp[sel];
    assign o_user   = mu[sel];

    sm4_axis_block_packer #(.S_BYTES(1), .USER_W(8), .PAD_MODE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata[7:0]), .s_axis_tkeep(tkeep[0:0]),
        .s_axis_tvalid(tv[0]), .s_axis_tready(trdy[0]), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .m_blk_data(md[0]), .m_blk_valid(mv[0]), .m_blk_ready(mr[0]), .m_blk_last(ml[0]),
        .m_blk_pad(mp[0]), .m_blk_user(mu[0]));

    sm4_axis_block_packer #(.S_BYTES(4), .USER_W(8), .PAD_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata[31:0]), .s_axis_tkeep(tkeep[3:0]),
        .s_axis_tvalid(tv[1]), .s_axis_tready(trdy[1]), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .m_blk_data(md[1]), .m_blk_valid(mv[1]), .m_blk_ready(mr[1]), .m_blk_last(ml[1]),
        .m_blk_pad(mp[1]), .m_blk_user(mu[1]));

    sm4_axis_block_packer #(.S_BYTES(16), .USER_W(8), .PAD_MODE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
        .s_axis_tvalid(tv[2]), .s_axis_tready(trdy[2]), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .m_blk_data(md[2]), .m_blk_valid(mv[2]), .m_blk_ready(mr[2]), .m_blk_last(ml[2]),
        .m_blk_pad(mp[2]), .m_blk_user(mu[2]));

    sm4_axis_block_packer #(.S_BYTES(16), .USER_W(8), .PAD_MODE(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
        .s_axis_tvalid(tv[3]), .s_axis_tready(trdy[3]), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .m_blk_data(md[3]), .m_blk_valid(mv[3]), .m_blk_ready(mr[3]), .m_blk_last(ml[3]),
        .m_blk_pad(mp[3]), .m_blk_user(mu[3]));

    // Scoreboard: a transfer happens on the next rising edge whenever valid and ready are high here
    always @(negedge clk) begin
        if (rst_n && o_valid && m_ready) begin
            mon_got = {o_data, o_last, o_pad, o_user};
            n_vec++;
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected sel=%0d got d=%h l=%b p=%0d u=%h, required no block",
                         sel, mon_got.d, mon_got.l, mon_got.p, mon_got.u);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_block sel=%0d got d=%h l=%b p=%0d u=%h required d=%h l=%b p=%0d u=%h",
                             sel, mon_got.d, mon_got.l, mon_got.p, mon_got.u,
                             mon_exp.d, mon_exp.l, mon_exp.p, mon_exp.u);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic select_cfg(input int c);
        sel    = 2'(c);
        cur_s  = (c == 0) ? 1 : (c == 1) ? 4 : 16;
        cur_pm = (c == 2) ? 0 : 1;
    endtask

    // Reference blocks for the packet in pkt, derived from the padding rules
    task automatic push_expected(input logic [7:0] u);
        int   n, nb, fill;
        blk_t e;
        n  = pkt.size();
        nb = (n + 15) / 16;
        for (int b = 0; b < nb; b++) begin
            fill = (n - 16*b < 16) ? (n - 16*b) : 16;
            for (int p = 0; p < 16; p++)
                e.d[127-8*p -: 8] = (p < fill) ? pkt[16*b + p] : ((cur_pm == 1) ? 8'(16 - fill) : 8'h00);
            e.p = (b == nb - 1) ? 5'(16 - fill) : 5'd0;
            e.l = (b == nb - 1) && !((cur_pm == 1) && (fill == 16));
            e.u = u;
            exp_q.push_back(e);
        end
        if ((cur_pm == 1) && (n % 16 == 0)) begin
            e.d = {16{8'h10}};
            e.l = 1'b1;
            e.p = 5'd16;
            e.u = u;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_beat(input logic [127:0] d, input logic [15:0] k, input logic l, input logic [7:0] u);
        int t;
        t = 0;
        tdata = d; tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (o_tready) break;
            t++;
            if (t > 300) begin
                n_vec++; n_fail++;
                $display("FAIL beat_timeout tready=0 for %0d cycles, required 1", t);
                break;
            end
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
    endtask

    // Drives pkt as beats; non-last keep and non-first tuser are randomised/inverted as noise
    task automatic send_beats(input logic [7:0] u, input bit kz, input bit with_last);
        int           n, idx, cnt;
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        n = pkt.size();
        idx = 0;
        while (idx < n) begin
            cnt = (n - idx < cur_s) ? (n - idx) : cur_s;
            l   = with_last && (idx + cnt == n);
            d   = {$urandom, $urandom, $urandom, $urandom};
            for (int j = 0; j < cnt; j++) d[8*j +: 8] = pkt[idx + j];
            k = 16'($urandom);
            if (l) begin
                if (kz && cnt == cur_s) k = 16'h0;
                else k = 16'((32'h1 << (cnt - 1)) | ($urandom & ((32'h1 << (cnt - 1)) - 1)));
            end
            drive_beat(d, k, l, (idx == 0) ? u : ~u);
            idx += cnt;
        end
    endtask

    task automatic send_pkt(input logic [7:0] u, input bit kz);
        push_expected(u);
        send_beats(u, kz, 1'b1);
    endtask

    task automatic make_seq(input int n, input logic [7:0] start);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'(start + 8'(i)));
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && t < 400) begin @(posedge clk); t++; end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain got %0d blocks pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic [139:0] got;
        select_cfg(0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            got = {trdy[i], mv[i], ml[i], mp[i], md[i], mu[i]};
            n_vec++;
            if (got !== 140'h0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d got %h, required 0", i, got);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_vec++;
        if (o_tready !== 1'b0) begin n_fail++; $display("FAIL reset_release_tready got %b, required 0", o_tready); end
        @(posedge clk); #1;
        n_vec++;
        if (o_tready !== 1'b1) begin n_fail++; $display("FAIL reset_first_edge_tready got %b, required 1", o_tready); end
    endtask

    task automatic test_full_then_padblk();
        select_cfg(0);
        make_seq(16, 8'h00);
        send_pkt(8'h09, 1'b0);
        wait_drain("full_padblk");
    endtask

    task automatic test_short_pkcs();
        select_cfg(1);
        pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_pkt(8'h5C, 1'b0);
        make_seq(8, 8'h40);
        send_pkt(8'h5A, 1'b1);
        wait_drain("short_pkcs");
    endtask

    task automatic test_zero_pad();
        select_cfg(2);
        make_seq(20, 8'h80);
        send_pkt(8'h21, 1'b0);
        make_seq(32, 8'h30);
        send_pkt(8'h22, 1'b0);
        wait_drain("zero_pad");
    endtask

    task automatic test_latency();
        logic [127:0] d;
        select_cfg(2);
        make_seq(16, 8'hC0);
        push_expected(8'h44);
        d = '0;
        for (int j = 0; j < 16; j++) d[8*j +: 8] = pkt[j];
        drive_beat(d, 16'hFFFF, 1'b1, 8'h44);
        n_vec++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL latency_edge_k got valid=%b, required 0", o_valid); end
        @(posedge clk); #1;
        n_vec++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL latency_edge_k1 got valid=%b, required 1", o_valid); end
        wait_drain("latency");
    endtask

    task automatic test_throughput();
        select_cfg(2);
        make_seq(64, 8'h10);
        xfer_cyc.delete();
        send_pkt(8'h55, 1'b0);
        wait_drain("tput16");
        n_vec++;
        if (xfer_cyc.size() != 4 || (xfer_cyc[3] - xfer_cyc[0]) != 6) begin
            n_fail++;
            $display("FAIL tput16 got %0d blocks over %0d cycles, required 4 over 6",
                     xfer_cyc.size(), (xfer_cyc.size() == 4) ? xfer_cyc[3] - xfer_cyc[0] : -1);
        end
        select_cfg(1);
        make_seq(32, 8'h60);
        xfer_cyc.delete();
        send_pkt(8'h56, 1'b0);
        wait_drain("tput4");
        n_vec++;
        if (xfer_cyc.size() != 3 || (xfer_cyc[1] - xfer_cyc[0]) != 5) begin
            n_fail++;
            $display("FAIL tput4 got %0d blocks spacing %0d, required 3 spacing 5",
                     xfer_cyc.size(), (xfer_cyc.size() >= 2) ? xfer_cyc[1] - xfer_cyc[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [141:0] snap, now;
        select_cfg(3);
        make_seq(48, 8'hA0);
        m_ready = 1'b0;
        fork
            send_pkt(8'h77, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1;
                snap = {o_data, o_last, o_pad, o_user, o_valid, o_tready};
                n_vec++;
                if (o_valid !== 1'b1 || o_tready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold got valid=%b tready=%b, required valid=1 tready=0", o_valid, o_tready);
                end
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk); #1;
                    now = {o_data, o_last, o_pad, o_user, o_valid, o_tready};
                    n_vec++;
                    if (now !== snap) begin
                        n_fail++;
                        $display("FAIL bp_stable cycle %0d got %h, required %h", c, now, snap);
                    end
                end
                m_ready = 1'b1;
            end
        join
        wait_drain("backpressure");
    endtask

    task automatic test_back_to_back();
        select_cfg(1);
        make_seq(20, 8'h01);
        send_pkt(8'h11, 1'b0);
        make_seq(8, 8'hF0);
        send_pkt(8'h22, 1'b0);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_midpacket();
        select_cfg(0);
        m_ready = 1'b1;
        make_seq(7, 8'h70);
        send_beats(8'h66, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (o_tready !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midpkt_reset got tready=%b valid=%b, required 0 0", o_tready, o_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        m_ready = 1'b0;
        make_seq(16, 8'h90);
        send_pkt(8'h67, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_data !== 128'h0) begin
            n_fail++;
            $display("FAIL held_reset got valid=%b data=%h, required 0 0", o_valid, o_data);
        end
        @(negedge clk); rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        pkt = '{8'hC1, 8'hC2, 8'hC3};
        send_pkt(8'h3C, 1'b0);
        wait_drain("reset_midpacket");
    endtask

    task automatic test_random();
        int n;
        select_cfg(1);
        rand_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            n = $urandom_range(1, 40);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            send_pkt(8'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        #2;
        wait_drain("random");
    endtask

    initial begin
        test_reset();
        test_full_then_padblk();
        test_short_pkcs();
        test_zero_pad();
        test_latency();
        test_throughput();
        test_backpressure();
        test_back_to_back();
        test_reset_midpacket();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
